// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment: shifts the read word down by the byte offset and
// sign- or zero-extends according to the RV32I load width.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      LB:      data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      data = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     data = {24'd0, shifted[7:0]};
      LHU:     data = {16'd0, shifted[15:0]};
      LW:      data = shifted;
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: single-outstanding request/grant/response data port,
// store lane replication, load alignment and misaligned/illegal detection.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  exc_misaligned,
  output logic                  exc_illegal,
  output logic [31:0]           exc_addr
);

  lsu_state_t state, state_next;

  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [4:0]            rd_q;
  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic                  fault_mis;
  logic                  go;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] align_data;

  assign in_ready = (state == IDLE);
  assign mem_req  = (state == REQ);

  always_comb begin
    accept     = in_valid && in_ready;
    illegal    = (is_load && is_store)
              || (is_load  && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
              || (is_store && (funct3 == 3'b011 || funct3[2]));
    misaligned = (funct3[1:0] == 2'b01 && addr[0])
              || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    // Misalignment only matters for a well-formed single-kind operation.
    fault_mis  = accept && (is_load || is_store) && !illegal && misaligned;
    go         = accept && (is_load ^ is_store) && !illegal && !misaligned;

    be_next    = 4'hF;
    wdata_next = '0;
    if (is_store) begin
      case (funct3)
        SB: begin
          be_next    = 4'b0001 << addr[1:0];
          wdata_next = {4{store_data[7:0]}};
        end
        SH: begin
          be_next    = 4'b0011 << addr[1:0];
          wdata_next = {2{store_data[15:0]}};
        end
        default: begin
          be_next    = 4'hF;
          wdata_next = store_data;
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = REQ;
      REQ:     if (mem_gnt) state_next = mem_we ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  load_align u_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (align_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_be         <= '0;
      mem_wdata      <= '0;
      f3_q           <= '0;
      off_q          <= '0;
      rd_q           <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      exc_misaligned <= 1'b0;
      exc_illegal    <= 1'b0;
      exc_addr       <= '0;
    end else begin
      state          <= state_next;
      wb_valid       <= 1'b0;
      exc_illegal    <= accept && illegal;
      exc_misaligned <= fault_mis;
      if ((accept && illegal) || fault_mis) exc_addr <= addr;
      if (go) begin
        mem_we    <= is_store;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be_next;
        mem_wdata <= wdata_next;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        rd_q      <= rd;
      end
      if (state == WAIT && mem_rvalid) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= align_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues operations and queues
// expected memory requests, writebacks and exceptions; a monitor checks them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misaligned, exc_illegal;
  logic [31:0] exc_addr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;
  typedef struct {
    logic        ill;
    logic [31:0] addr;
  } exc_exp_t;

  mem_exp_t mem_q[$];
  wb_exp_t  wb_q[$];
  exc_exp_t exc_q[$];

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: access size in bytes, legality, lanes and extended load value.
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_illegal(input bit ld, input bit st, input logic [2:0] f3);
    if (ld && st) return 1'b1;
    if (ld) return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (st) return !(f3 inside {3'd0, 3'd1, 3'd2});
    return 1'b0;
  endfunction

  function automatic logic [3:0] be_of(input logic [31:0] a, input int n);
    logic [3:0] b;
    int o = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = (i >= o) && (i < o + n);
    return b;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [31:0] d, input int n);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    int     n = size_of(f3);
    int     o = int'(a % 4);
    longint v = longint'(rdata >> (8 * o));
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (f3 < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return v[31:0];
  endfunction

  task automatic randomize_inputs();
    is_load    = 1'($urandom);
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
    rd         = 5'($urandom);
  endtask

  // Drive one operation to completion; called just after a rising edge.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r, input int gdly, input int rdly,
                       input logic [31:0] rdata, input bit noise);
    bit ill, mis, mem_op;
    int n, w;
    mem_exp_t me;
    n      = size_of(f3);
    ill    = is_illegal(ld, st, f3);
    mis    = !ill && (ld || st) && ((a % n) != 0);
    mem_op = (ld || st) && !ill && !mis;
    if (ill || mis) exc_q.push_back('{ill, a});
    if (mem_op) begin
      me.addr  = {a[31:2], 2'b00};
      me.we    = st;
      me.be    = st ? be_of(a, n) : 4'hF;
      me.wdata = wdata_of(d, n);
      mem_q.push_back(me);
    end
    in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = d; rd = r;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    randomize_inputs();
    if (!mem_op) begin
      check("in_ready_after_fault_or_drop", 32'(in_ready), 32'd1);
      return;
    end
    for (int i = 0; i < gdly; i++) begin
      check("in_ready_low_in_req", 32'(in_ready), 32'd0);
      if (noise) begin
        randomize_inputs();
        in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (st) begin
      check("in_ready_after_store", 32'(in_ready), 32'd1);
      return;
    end
    for (int i = 0; i < rdly; i++) begin
      check("in_ready_low_in_wait", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    wb_q.push_back('{r, load_value(f3, a, rdata)});
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    check("in_ready_after_load", 32'(in_ready), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (mem_q.size() == 0) check("mem_req_unexpected", 32'(mem_req), 32'd0);
        else begin
          check("mem_addr", mem_addr, mem_q[0].addr);
          check("mem_we", 32'(mem_we), 32'(mem_q[0].we));
          check("mem_be", 32'(mem_be), 32'(mem_q[0].be));
          if (mem_q[0].we) check("mem_wdata", mem_wdata, mem_q[0].wdata);
          if (mem_gnt) void'(mem_q.pop_front());
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) check("wb_valid_unexpected", 32'(wb_valid), 32'd0);
        else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
        end
      end
      if (exc_misaligned || exc_illegal) begin
        if (exc_q.size() == 0) check("exc_unexpected", 32'({exc_illegal, exc_misaligned}), 32'd0);
        else begin
          exc_exp_t e;
          e = exc_q.pop_front();
          check("exc_kind", 32'({exc_illegal, exc_misaligned}), e.ill ? 32'd2 : 32'd1);
          check("exc_addr", exc_addr, e.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ld, st;
    logic [2:0] f3;
    logic [31:0] a;
    int k;
    rst = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_exc", 32'({exc_illegal, exc_misaligned}), 32'd0);
    check("rst_exc_addr", exc_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed stores and loads
    issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0, 0);
    issue(0, 1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 1, 0, 32'h0, 0);
    issue(0, 1, 3'b001, 32'h102, 32'h00001234, 5'd0, 0, 0, 32'h0, 0);
    issue(1, 0, 3'b000, 32'h201, 32'h0, 5'd1, 0, 0, 32'h80FF7F01, 0);
    issue(1, 0, 3'b100, 32'h201, 32'h0, 5'd2, 1, 2, 32'h80FF7F01, 0);
    issue(1, 0, 3'b000, 32'h202, 32'h0, 5'd3, 0, 1, 32'h80FF7F01, 0);
    issue(1, 0, 3'b101, 32'h202, 32'h0, 5'd4, 2, 0, 32'h80FF7F01, 0);
    issue(1, 0, 3'b001, 32'h202, 32'h0, 5'd5, 0, 0, 32'h80FF7F01, 0);
    issue(1, 0, 3'b010, 32'h200, 32'h0, 5'd6, 0, 0, 32'h80FF7F01, 0);

    // Faults and dropped operations
    issue(1, 0, 3'b010, 32'h102, 32'h0, 5'd7, 0, 0, 32'h0, 0);
    issue(1, 0, 3'b011, 32'h104, 32'h0, 5'd7, 0, 0, 32'h0, 0);
    issue(0, 1, 3'b101, 32'h108, 32'h0, 5'd7, 0, 0, 32'h0, 0);
    issue(1, 1, 3'b010, 32'h10C, 32'h0, 5'd7, 0, 0, 32'h0, 0);
    issue(0, 0, 3'b010, 32'h110, 32'h0, 5'd7, 0, 0, 32'h0, 0);

    // Back-to-back faults on consecutive cycles
    exc_q.push_back('{1'b1, 32'h120});
    exc_q.push_back('{1'b0, 32'h131});
    in_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b111; addr = 32'h120;
    @(posedge clk); #1;
    is_load = 1'b1; is_store = 1'b0; funct3 = 3'b001; addr = 32'h131;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Grant withheld with upstream noise
    issue(0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 5'd0, 5, 0, 32'h0, 1);
    issue(1, 0, 3'b001, 32'h402, 32'h0, 5'd8, 5, 3, 32'h1234ABCD, 1);

    // Reset while waiting for read data
    mem_q.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
    in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300; rd = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_mem_be", 32'(mem_be), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    check("mid_rst_wb_data", wb_data, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("late_rvalid_no_wb", 32'(wb_valid), 32'd0);
    check("late_rvalid_in_ready", 32'(in_ready), 32'd1);
    issue(1, 0, 3'b000, 32'h303, 32'h0, 5'd10, 0, 0, 32'h91000000, 0);

    // Randomized operations
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      ld = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom);
      st = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : !ld;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (ld ? 3'(k % 2 ? 4 + $urandom_range(0, 1) : $urandom_range(0, 2)) : 3'($urandom_range(0, 2)));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(ld, st, f3, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    check("exc_q_drained", 32'(exc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage directly downstream of the execute ALU: accepts the ALU-computed effective address plus store data and `funct3` for one RV32I load or store. It then drives a single-outstanding request/grant/response data-memory port with byte enables and lane-replicated store data. Load results are aligned and sign- or zero-extended, and returned as a one-cycle writeback. Misaligned and illegal encodings are flagged without touching memory.

## Interface
- `DATA_WIDTH`, 32, datapath width; only 32 is supported
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  execute presents an operation
- `in_ready`  out  1  unit can accept; high only in IDLE
- `is_load` / `is_store`  in  1 each  operation kind; at most one high
- `funct3`  in  3  RV32I width/sign field
- `addr`  in  32  effective address (ALU output)
- `store_data`  in  32  rs2 value
- `rd`  in  5  load destination register
- `mem_req`  out  1  request valid
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read word
- `wb_valid`  out  1  one-cycle load result pulse
- `wb_rd`  out  5  destination register
- `wb_data`  out  32  extended load value
- `exc_misaligned`  out  1  one-cycle pulse
- `exc_illegal`  out  1  one-cycle pulse
- `exc_addr`  out  32  faulting byte address, valid with either exc pulse

## Operation
- States: IDLE, REQ, WAIT.
- IDLE, `in_valid` high:
  - Capture addr, funct3, rd, kind and store data.
  - Illegal: load funct3 3/6/7, store funct3 3–7, or both kinds high. Pulse `exc_illegal` next cycle and stay in IDLE.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Pulse `exc_misaligned` next cycle and stay in IDLE.
  - Neither kind high: accepted and dropped.
  - Otherwise: go to REQ.
- REQ:
  - `mem_req`=1; addr/we/be/wdata held stable until `mem_gnt`.
  - On grant, a store goes to IDLE and a load goes to WAIT.
- WAIT:
  - On `mem_rvalid`, register the extracted value into `wb_data`, pulse `wb_valid` the next cycle and go to IDLE.
- Byte lanes, with o = addr[1:0]:
  - SB: be = 1<<o, wdata = {4{d[7:0]}}.
  - SH: be = 4'b0011<<o, wdata = {2{d[15:0]}}.
  - SW: be = 4'hF.
  - Loads: mem_be = 4'hF.
- Load extraction: shift rdata right by 8·o.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- `mem_rvalid` outside WAIT and `mem_gnt` outside REQ are ignored.

## Timing
- Reset values: in_ready=1; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; wb_valid=0, wb_rd=0, wb_data=0; exc_misaligned=0, exc_illegal=0, exc_addr=0; state IDLE.
- Accept edge T → `mem_req` high in cycle T+1 (registered outputs).
- Store with grant in T+1 → in_ready high in T+2; minimum 2 cycles per store.
- Load:
  - `mem_rvalid` arrives no earlier than the cycle after grant.
  - rvalid in cycle R → wb_valid in R+1, with in_ready already high in R+1.
  - Minimum 3 cycles per load.
- Exception pulse occurs in T+1, with in_ready high in T+1. Back-to-back faults pulse on consecutive cycles.
- No new accept while not in IDLE. Upstream must hold operands until accepted.
- Reset mid-operation:
  - `mem_req` drops at the reset edge and no writeback is produced.
  - A later rvalid for the abandoned load is ignored.
- Grant held off indefinitely: stay in REQ with outputs stable.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - `lsu_state_t` enum {IDLE, REQ, WAIT}.
- Sub-module `load_align`: combinational (rdata, offset, funct3) → 32-bit extended value.
- Store lane and byte-enable generation stays inline in the top module.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, grant on first cycle → mem_addr 0x100, be 4'hF, wdata 0xDEADBEEF, no wb_valid, in_ready back 2 cycles after accept.
- SB addr 0x103, data 0x000000A5 → be 4'b1000, wdata 0xA5A5A5A5. SH addr 0x102, data 0x1234 → be 4'b1100, wdata 0x12341234.
- Loads from addr 0x201 with rdata 0x80FF7F01:
  - LB → wb_data 0x0000007F.
  - LBU → 0x0000007F.
  - LB from 0x202 → 0xFFFFFFFF.
  - LHU from 0x202 → 0x000080FF.
  - LH from 0x202 → 0xFFFF80FF.
- LW addr 0x102 → exc_misaligned pulse, exc_addr 0x102, mem_req never asserted. Load funct3 3'b011 → exc_illegal pulse.
- Grant withheld 5 cycles with random upstream in_valid → mem_* stable, in_ready low throughout, exactly one transaction.
- rst asserted during WAIT, then rvalid arrives → no wb_valid, all outputs at reset values, next load completes normally.
